chroni_vram_arb: RTL and testbench

CHRONI_VRAM_ARB -- requirements
Module: chroni_vram_arb

---
 rtl/chroni_pkg.sv | 13 +
 rtl/chroni_vram_ram.sv | 23 ++
 rtl/chroni_vram_arb.sv | 116 +++++++++++
 tb/tb_chroni_vram_arb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/chroni_pkg.sv
// rtl/chroni_pkg.sv - shared VRAM geometry defaults and CPU arbiter state encoding
package chroni_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } cpu_state_t;

endpackage

// File: rtl/chroni_vram_ram.sv
// rtl/chroni_vram_ram.sv - single-port synchronous VRAM, one access per cycle, 1-cycle read latency
module chroni_vram_ram
  import chroni_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately not reset so the screen survives a reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/chroni_vram_arb.sv
// rtl/chroni_vram_arb.sv - VRAM arbiter, video has absolute priority over a one-entry CPU port
// CHRONI_VRAM_CPU_READ_EN enables CPU reads; without it the CPU port is write-only.
module chroni_vram_arb
  import chroni_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata
);

  cpu_state_t        state;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              req_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              vid_rd_q;
  logic [DATA_W-1:0] vid_hold;

`ifdef CHRONI_VRAM_CPU_READ_EN
  assign req_we = cpu_we;
`else
  // Every request becomes a write; cpu_we stays referenced but has no effect.
  assign req_we = cpu_we | 1'b1;
`endif

  // The CPU only reaches the RAM in PEND cycles the video port leaves free.
  assign ram_addr = vid_req ? vid_addr : cap_addr;
  assign ram_we   = reset_n && !vid_req && (state == PEND) && cap_we;

  chroni_vram_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (vga_clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (cap_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cpu_busy  <= 1'b0;
      cpu_ack   <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: if (cpu_req) begin
          cap_we    <= req_we;
          cap_addr  <= cpu_addr;
          cap_wdata <= cpu_wdata;
          cpu_busy  <= 1'b1;
          state     <= PEND;
        end
        PEND: if (!vid_req) begin
          cpu_ack <= 1'b1;
          state   <= ACK;
        end
        ACK: begin
          cpu_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM output register is shared, so each port keeps a copy of its last result.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      vid_rd_q <= 1'b0;
      vid_hold <= '0;
    end else begin
      vid_rd_q <= vid_req;
      vid_hold <= vid_data;
    end
  end

  assign vid_data = vid_rd_q ? ram_rdata : vid_hold;

`ifdef CHRONI_VRAM_CPU_READ_EN
  logic              rd_ack;
  logic [DATA_W-1:0] rdata_hold;

  assign rd_ack = (state == ACK) && !cap_we;

  always_ff @(posedge vga_clk) begin
    if (!reset_n)    rdata_hold <= '0;
    else if (rd_ack) rdata_hold <= ram_rdata;
  end

  assign cpu_rdata = rd_ack ? ram_rdata : rdata_hold;
`else
  assign cpu_rdata = '0;
`endif

endmodule

// File: tb/tb_chroni_vram_arb.sv
// tb/tb_chroni_vram_arb.sv - randomized self-checking bench for chroni_vram_arb against a transaction model
module tb_chroni_vram_arb;

  localparam int AW = 11;
  localparam int DW = 8;

`ifdef CHRONI_VRAM_CPU_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic          vga_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_busy;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  always #5 vga_clk = ~vga_clk;

  chroni_vram_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_busy  (cpu_busy),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Transaction-level model: one outstanding CPU request, served in the first video-free cycle.
  logic [DW-1:0] m_mem [2**AW];
  bit            in_flight = 1'b0;
  bit            accessed = 1'b0;
  int            ack_cyc = -1;
  bit            p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wd;
  logic [DW-1:0] rd_val;
  logic [DW-1:0] exp_vid = '0;
  logic [DW-1:0] exp_rdata = '0;
  bit            exp_ack = 1'b0;
  bit            exp_busy = 1'b0;

  // Drive one cycle of inputs, advance the model, land 1 time unit after the next rising edge.
  task automatic cycle(input bit rst, input bit vr, input logic [AW-1:0] va,
                       input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    logic [DW-1:0] nv;
    reset_n = !rst; vid_req = vr; vid_addr = va;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    nv = exp_vid;
    if (rst) begin
      in_flight = 1'b0; ack_cyc = -1; nv = '0; exp_rdata = '0;
    end else begin
      if (vr) nv = m_mem[va];
      if (in_flight && !accessed && !vr) begin
        accessed = 1'b1;
        ack_cyc  = cyc + 1;
        if (p_we) m_mem[p_addr] = p_wd;
        else      rd_val = m_mem[p_addr];
      end
      if (in_flight && ack_cyc == cyc) begin
        in_flight = 1'b0;
      end else if (!in_flight && cr) begin
        in_flight = 1'b1; accessed = 1'b0; ack_cyc = -1;
        p_we = READ_EN ? cw : 1'b1; p_addr = ca; p_wd = cd;
      end
    end
    exp_vid  = nv;
    exp_ack  = !rst && (ack_cyc == cyc + 1);
    exp_busy = in_flight;
    if (exp_ack && !p_we) exp_rdata = rd_val;
    @(posedge vga_clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0, '0, '0);
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cycle(0, 0, '0, 1, 1, a, d);
    for (int k = 0; k < 8 && in_flight; k++) idle(1);
  endtask

  task automatic test_reset();
    cycle(1, 0, '0, 0, 0, '0, '0);
    cycle(1, 0, '0, 1, 1, 11'h001, 8'hFF);
    n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", cpu_busy); end
    n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", cpu_ack); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", cpu_rdata); end
    n_checks++; if (vid_data !== 8'h00) begin n_fail++; $display("FAIL reset_vid: got %h want 00", vid_data); end
    idle(1);
  endtask

  task automatic test_prefill();
    for (int i = 0; i < 16; i++) cpu_wr(11'h200 + AW'(i), DW'($urandom));
  endtask

  task automatic test_write_basic();
    cycle(0, 0, '0, 1, 1, 11'h400, 8'h41);
    n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_n1: got %b want 1", cpu_busy); end
    n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_n1: got %b want 0", cpu_ack); end
    idle(1);
    n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_n2: got %b want 1", cpu_busy); end
    n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack_n2: got %b want 1", cpu_ack); end
    idle(1);
    n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_n3: got %b want 0", cpu_busy); end
    n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_n3: got %b want 0", cpu_ack); end
    cycle(0, 1, 11'h400, 0, 0, '0, '0);
    n_checks++; if (vid_data !== 8'h41) begin n_fail++; $display("FAIL wr_vid_readback: got %h want 41", vid_data); end
  endtask

  task automatic test_vid_priority();
    logic [DW-1:0] d;
    d = DW'($urandom);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 11'h200 + AW'($urandom_range(0, 15)), i == 0, 1, 11'h123, d);
      n_checks++; if (vid_data !== exp_vid) begin n_fail++; $display("FAIL prio_vid[%0d]: got %h want %h", i, vid_data, exp_vid); end
      n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL prio_early_ack[%0d]: got %b want 0", i, cpu_ack); end
      n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy[%0d]: got %b want 1", i, cpu_busy); end
    end
    idle(1);
    n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL prio_ack: got %b want 1", cpu_ack); end
    idle(1);
    n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL prio_ack_width: got %b want 0", cpu_ack); end
    cycle(0, 1, 11'h123, 0, 0, '0, '0);
    n_checks++; if (vid_data !== d) begin n_fail++; $display("FAIL prio_wdata: got %h want %h", vid_data, d); end
  endtask

  task automatic test_cpu_read();
    cpu_wr(11'h7FF, 8'hA5);
    cycle(0, 0, '0, 1, 0, 11'h7FF, 8'h00);
    idle(1);
    n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack: got %b want 1", cpu_ack); end
    n_checks++; if (cpu_rdata !== (READ_EN ? 8'hA5 : 8'h00)) begin n_fail++; $display("FAIL rd_data: got %h want %h", cpu_rdata, READ_EN ? 8'hA5 : 8'h00); end
    idle(1);
    cpu_wr(11'h7FE, 8'h3C);
    n_checks++; if (cpu_rdata !== (READ_EN ? 8'hA5 : 8'h00)) begin n_fail++; $display("FAIL rd_hold: got %h want %h", cpu_rdata, READ_EN ? 8'hA5 : 8'h00); end
  endtask

  task automatic test_busy_ignore();
    int acks;
    cpu_wr(11'h056, 8'h77);
    acks = 0;
    cycle(0, 0, '0, 1, 1, 11'h055, 8'h11); acks += int'(cpu_ack);
    cycle(0, 0, '0, 1, 1, 11'h055, 8'h22); acks += int'(cpu_ack);
    cycle(0, 0, '0, 1, 1, 11'h056, 8'h33); acks += int'(cpu_ack);
    for (int i = 0; i < 5; i++) begin idle(1); acks += int'(cpu_ack); end
    n_checks++; if (acks != 1) begin n_fail++; $display("FAIL ign_ack_count: got %0d want 1", acks); end
    cycle(0, 1, 11'h055, 0, 0, '0, '0);
    n_checks++; if (vid_data !== 8'h11) begin n_fail++; $display("FAIL ign_first: got %h want 11", vid_data); end
    cycle(0, 1, 11'h056, 0, 0, '0, '0);
    n_checks++; if (vid_data !== 8'h77) begin n_fail++; $display("FAIL ign_untouched: got %h want 77", vid_data); end
  endtask

  task automatic test_reset_pend();
    int acks;
    cpu_wr(11'h300, 8'h5A);
    cycle(0, 1, 11'h300, 1, 1, 11'h300, 8'hFF);
    cycle(0, 1, 11'h300, 0, 0, '0, '0);
    n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL rp_busy_pend: got %b want 1", cpu_busy); end
    cycle(1, 1, 11'h300, 0, 0, '0, '0);
    n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL rp_busy_cleared: got %b want 0", cpu_busy); end
    n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rp_ack: got %b want 0", cpu_ack); end
    acks = 0;
    for (int i = 0; i < 4; i++) begin idle(1); acks += int'(cpu_ack); end
    n_checks++; if (acks != 0) begin n_fail++; $display("FAIL rp_late_ack: got %0d want 0", acks); end
    cycle(0, 1, 11'h300, 0, 0, '0, '0);
    n_checks++; if (vid_data !== 8'h5A) begin n_fail++; $display("FAIL rp_retained: got %h want 5a", vid_data); end
  endtask

  task automatic test_write_only();
    cpu_wr(11'h010, 8'hC3);
    cycle(0, 0, '0, 1, 0, 11'h010, 8'h3C);
    idle(1);
    n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wo_ack: got %b want 1", cpu_ack); end
    n_checks++; if (cpu_rdata !== (READ_EN ? 8'hC3 : 8'h00)) begin n_fail++; $display("FAIL wo_rdata: got %h want %h", cpu_rdata, READ_EN ? 8'hC3 : 8'h00); end
    idle(1);
    cycle(0, 1, 11'h010, 0, 0, '0, '0);
    n_checks++; if (vid_data !== (READ_EN ? 8'hC3 : 8'h3C)) begin n_fail++; $display("FAIL wo_mem: got %h want %h", vid_data, READ_EN ? 8'hC3 : 8'h3C); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(0, $urandom_range(0, 2) == 0, 11'h200 + AW'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            11'h200 + AW'($urandom_range(0, 15)), DW'($urandom));
      n_checks++; if (vid_data !== exp_vid) begin n_fail++; $display("FAIL rnd_vid @%0d: got %h want %h", cyc, vid_data, exp_vid); end
      n_checks++; if (cpu_ack !== exp_ack) begin n_fail++; $display("FAIL rnd_ack @%0d: got %b want %b", cyc, cpu_ack, exp_ack); end
      n_checks++; if (cpu_busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy @%0d: got %b want %b", cyc, cpu_busy, exp_busy); end
      n_checks++; if (cpu_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata @%0d: got %h want %h", cyc, cpu_rdata, exp_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_write_basic();
    test_vid_priority();
    test_cpu_read();
    test_busy_ignore();
    test_reset_pend();
    test_write_only();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
